// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares the register file write port between the execute
// unit (port 0) and the load/store unit (port 1), with a starvation bound on port 0.
module wb_arbiter #(
   parameter int XLEN     = 32,
   parameter int RS_W     = 5,
   parameter int MAX_WAIT = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            hold_i,
   input  logic            valid0_i,
   input  logic [RS_W-1:0] rd0_i,
   input  logic [XLEN-1:0] wdata0_i,
   output logic            ready0_o,
   input  logic            valid1_i,
   input  logic [RS_W-1:0] rd1_i,
   input  logic [XLEN-1:0] wdata1_i,
   output logic            ready1_o,
   output logic            wen_o,
   output logic [RS_W-1:0] rd_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [31:0]     conflict_cnt_o
);

   localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

   logic [3:0]      wait_q;
   logic [3:0]      wait_d;
   logic            gnt0;
   logic            gnt1;
   logic            gnt_any;
   logic            conflict;
   logic [RS_W-1:0] sel_rd;
   logic [XLEN-1:0] sel_wdata;
   logic            wen_q;
   logic [RS_W-1:0] rd_q;
   logic [XLEN-1:0] wdata_q;
   logic [31:0]     conflict_q;

   // LSU wins contention until the EXU has been refused WAIT_LIM times in a row.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst_i && !hold_i) begin
         if (valid0_i && valid1_i) begin
            if (wait_q >= WAIT_LIM) gnt0 = 1'b1;
            else                    gnt1 = 1'b1;
         end else if (valid0_i) begin
            gnt0 = 1'b1;
         end else if (valid1_i) begin
            gnt1 = 1'b1;
         end
      end
   end

   assign gnt_any   = gnt0 | gnt1;
   assign conflict  = valid0_i & valid1_i & ~hold_i;
   assign sel_rd    = gnt0 ? rd0_i    : rd1_i;
   assign sel_wdata = gnt0 ? wdata0_i : wdata1_i;

   always_comb begin
      wait_d = wait_q;
      if (!hold_i) begin
         if (!valid0_i || gnt0)    wait_d = 4'd0;
         else if (wait_q < WAIT_LIM) wait_d = wait_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wait_q     <= 4'd0;
         conflict_q <= 32'd0;
      end else begin
         wait_q <= wait_d;
         if (conflict) conflict_q <= conflict_q + 32'd1;
      end
   end

   // x0 writes are accepted but never reach the register file.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wen_q   <= 1'b0;
         rd_q    <= '0;
         wdata_q <= '0;
      end else begin
         wen_q <= gnt_any && (sel_rd != '0);
         if (gnt_any) begin
            rd_q    <= sel_rd;
            wdata_q <= sel_wdata;
         end
      end
   end

   assign ready0_o       = gnt0;
   assign ready1_o       = gnt1;
   assign wen_o          = wen_q;
   assign rd_o           = rd_q;
   assign wdata_o        = wdata_q;
   assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table for grants, scoreboard queue
// for the registered write port, plus reset and counter-wrap sequences.
module tb_wb_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        hold_i;
   logic        valid0_i;
   logic [4:0]  rd0_i;
   logic [31:0] wdata0_i;
   logic        ready0_o;
   logic        valid1_i;
   logic [4:0]  rd1_i;
   logic [31:0] wdata1_i;
   logic        ready1_o;
   logic        wen_o;
   logic [4:0]  rd_o;
   logic [31:0] wdata_o;
   logic [31:0] conflict_cnt_o;

   wb_arbiter #(.XLEN(32), .RS_W(5), .MAX_WAIT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i),
      .valid0_i(valid0_i), .rd0_i(rd0_i), .wdata0_i(wdata0_i), .ready0_o(ready0_o),
      .valid1_i(valid1_i), .rd1_i(rd1_i), .wdata1_i(wdata1_i), .ready1_o(ready1_o),
      .wen_o(wen_o), .rd_o(rd_o), .wdata_o(wdata_o), .conflict_cnt_o(conflict_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        v0;
      logic [4:0]  rd0;
      logic [31:0] wd0;
      logic        v1;
      logic [4:0]  rd1;
      logic [31:0] wd1;
      logic        hold;
      logic        r0;
      logic        r1;
   } vec_t;

   typedef struct {
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] wdata;
   } wr_t;

   vec_t        vecs[$];
   wr_t         sb[$];
   int          total = 0;
   int          bad   = 0;
   logic [4:0]  m_rd;
   logic [31:0] m_wdata;
   logic [31:0] m_conf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v0, input logic [4:0] rd0, input logic [31:0] wd0,
                               input logic v1, input logic [4:0] rd1, input logic [31:0] wd1,
                               input logic hold, input logic r0, input logic r1);
      vec_t v;
      v.v0 = v0; v.rd0 = rd0; v.wd0 = wd0;
      v.v1 = v1; v.rd1 = rd1; v.wd1 = wd1;
      v.hold = hold; v.r0 = r0; v.r1 = r1;
      return v;
   endfunction

   function automatic vec_t both(input logic hold, input logic r0, input logic r1);
      return mk(1'b1, 5'd1, 32'h0000_00A0, 1'b1, 5'd2, 32'h0000_00B0, hold, r0, r1);
   endfunction

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic step(input vec_t v, input string tag);
      wr_t e;
      wr_t got;
      hold_i   = v.hold;
      valid0_i = v.v0; rd0_i = v.rd0; wdata0_i = v.wd0;
      valid1_i = v.v1; rd1_i = v.rd1; wdata1_i = v.wd1;
      #1;
      chk({tag, " ready0"}, {31'd0, ready0_o}, {31'd0, v.r0});
      chk({tag, " ready1"}, {31'd0, ready1_o}, {31'd0, v.r1});
      chk({tag, " one_hot"}, {31'd0, ready0_o & ready1_o}, 32'd0);
      if (v.r0) begin m_rd = v.rd0; m_wdata = v.wd0; end
      else if (v.r1) begin m_rd = v.rd1; m_wdata = v.wd1; end
      e.wen   = (v.r0 || v.r1) && (m_rd != 5'd0);
      e.rd    = m_rd;
      e.wdata = m_wdata;
      sb.push_back(e);
      if (v.v0 && v.v1 && !v.hold) m_conf = m_conf + 32'd1;
      @(posedge clk_i);
      #1;
      if (sb.size() == 0) begin
         chk({tag, " sb_empty"}, 32'd0, 32'd1);
      end else begin
         got = sb.pop_front();
         chk({tag, " wen"},   {31'd0, wen_o}, {31'd0, got.wen});
         chk({tag, " rd"},    {27'd0, rd_o},  {27'd0, got.rd});
         chk({tag, " wdata"}, wdata_o, got.wdata);
      end
      chk({tag, " conflict"}, conflict_cnt_o, m_conf);
      @(negedge clk_i);
   endtask

   initial begin
      vecs.push_back(mk(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0));
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 4; j++) vecs.push_back(both(1'b0, 1'b0, 1'b1));
         vecs.push_back(both(1'b0, 1'b1, 1'b0));
      end
      vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 1'b0, 1'b1));
      vecs.push_back(both(1'b0, 1'b0, 1'b1));
      vecs.push_back(both(1'b0, 1'b0, 1'b1));
      for (int j = 0; j < 3; j++) vecs.push_back(both(1'b1, 1'b0, 1'b0));
      vecs.push_back(both(1'b0, 1'b0, 1'b1));
      vecs.push_back(both(1'b0, 1'b0, 1'b1));
      vecs.push_back(both(1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 5'd3, 32'd9, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 5'd7, 32'd1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 5'd7, 32'd2, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 5'd0, 32'd3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 32'hFFFF_0000, 1'b0, 1'b0, 1'b1));

      // Reset with requests pending: nothing may be granted.
      rst_i = 1'b1; hold_i = 1'b0;
      valid0_i = 1'b1; rd0_i = 5'd4; wdata0_i = 32'h11;
      valid1_i = 1'b1; rd1_i = 5'd6; wdata1_i = 32'h22;
      #3;
      chk("rst ready0", {31'd0, ready0_o}, 32'd0);
      chk("rst ready1", {31'd0, ready1_o}, 32'd0);
      chk("rst wen", {31'd0, wen_o}, 32'd0);
      chk("rst rd", {27'd0, rd_o}, 32'd0);
      chk("rst wdata", wdata_o, 32'd0);
      chk("rst conflict", conflict_cnt_o, 32'd0);
      @(negedge clk_i);
      valid0_i = 1'b0; valid1_i = 1'b0;
      rst_i = 1'b0;
      m_rd = 5'd0; m_wdata = 32'd0; m_conf = 32'd0;

      for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

      // Asynchronous reset right after a grant discards the pending write.
      step(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0055, 1'b0, 1'b0, 1'b1), "pre_rst");
      rst_i = 1'b1;
      #1;
      chk("midrst wen", {31'd0, wen_o}, 32'd0);
      chk("midrst rd", {27'd0, rd_o}, 32'd0);
      chk("midrst conflict", conflict_cnt_o, 32'd0);
      chk("midrst ready1", {31'd0, ready1_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      sb.delete();
      m_rd = 5'd0; m_wdata = 32'd0; m_conf = 32'd0;
      step(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0055, 1'b0, 1'b0, 1'b1), "post_rst");

      // Conflict counter wrap from an all-ones preload.
      force dut.conflict_q = 32'hFFFF_FFFF;
      #1;
      release dut.conflict_q;
      m_conf = 32'hFFFF_FFFF;
      chk("preload", conflict_cnt_o, m_conf);
      step(both(1'b0, 1'b0, 1'b1), "wrap");
      chk("wrap zero", conflict_cnt_o, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
